// File: rtl/pacman_sprite_sequencer.sv
// Pac-Man sprite animation controller: picks the sprite/palette set for the pixel path.
// All animation state advances only on the vertical-blank frame tick.
module pacman_sprite_sequencer #(
   parameter int TICKS_PER_PHASE       = 4,
   parameter int DEATH_FRAMES          = 11,
   parameter int DEATH_TICKS_PER_FRAME = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [1:0] dir,
   input  logic       moving,
   input  logic       die,
   input  logic       restart,
   output logic [4:0] sprite_sel,
   output logic [1:0] mouth,
   output logic       dying,
   output logic       anim_done,
   output logic       sel_changed
);

   localparam int CNT_MAX = (TICKS_PER_PHASE > DEATH_TICKS_PER_FRAME) ?
                            TICKS_PER_PHASE : DEATH_TICKS_PER_FRAME;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int FRM_W   = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

   localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(TICKS_PER_PHASE - 1);
   localparam logic [CNT_W-1:0] DTICK_LAST = CNT_W'(DEATH_TICKS_PER_FRAME - 1);
   localparam logic [FRM_W-1:0] FRAME_LAST = FRM_W'(DEATH_FRAMES - 1);

   typedef enum logic [1:0] {ALIVE, DYING, DEAD} state_t;

   state_t           state, n_state;
   logic [1:0]       dir_q, n_dir;
   logic [1:0]       phase, n_phase;
   logic [CNT_W-1:0] tick_cnt, n_cnt;
   logic [FRM_W-1:0] death_frame, n_frame;
   logic             die_pend, n_pend;
   logic [1:0]       n_mouth;
   logic [4:0]       n_sel;

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      n_state = state;
      n_dir   = dir_q;
      n_phase = phase;
      n_cnt   = tick_cnt;
      n_frame = death_frame;
      n_pend  = die_pend;

      if (restart) begin
         n_state = ALIVE;
         n_dir   = 2'b00;
         n_phase = 2'd0;
         n_cnt   = '0;
         n_frame = '0;
         n_pend  = 1'b0;
      end else begin
         case (state)
            ALIVE: begin
               if (frame_tick && die_pend) begin
                  // A pending death outranks movement on the same tick.
                  n_state = DYING;
                  n_frame = '0;
                  n_cnt   = '0;
                  n_pend  = 1'b0;
               end else begin
                  if (die)
                     n_pend = 1'b1;
                  if (frame_tick && moving) begin
                     n_dir = dir;
                     if (tick_cnt == PHASE_LAST) begin
                        n_cnt   = '0;
                        n_phase = phase + 2'd1;
                     end else begin
                        n_cnt = tick_cnt + 1'b1;
                     end
                  end
               end
            end
            DYING: begin
               if (frame_tick) begin
                  if (tick_cnt == DTICK_LAST) begin
                     n_cnt = '0;
                     if (death_frame == FRAME_LAST)
                        n_state = DEAD;
                     else
                        n_frame = death_frame + 1'b1;
                  end else begin
                     n_cnt = tick_cnt + 1'b1;
                  end
               end
            end
            DEAD: ;
            default: n_state = ALIVE;
         endcase
      end

      case (n_phase)
         2'd0:    n_mouth = 2'b00;
         2'd2:    n_mouth = 2'b10;
         default: n_mouth = 2'b01;
      endcase

      case (n_state)
         ALIVE:   n_sel = {1'b0, n_dir, n_mouth};
         DYING:   n_sel = {1'b1, 4'(n_frame)};
         default: n_sel = 5'b11111;
      endcase
   end

   // NOTE: non-blocking assignments only here; outputs are registered alongside the state they reflect.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= ALIVE;
         dir_q       <= 2'b00;
         phase       <= 2'd0;
         tick_cnt    <= '0;
         death_frame <= '0;
         die_pend    <= 1'b0;
         sprite_sel  <= 5'b00000;
         mouth       <= 2'b00;
         dying       <= 1'b0;
         anim_done   <= 1'b0;
         sel_changed <= 1'b0;
      end else begin
         state       <= n_state;
         dir_q       <= n_dir;
         phase       <= n_phase;
         tick_cnt    <= n_cnt;
         death_frame <= n_frame;
         die_pend    <= n_pend;
         sprite_sel  <= n_sel;
         mouth       <= n_mouth;
         dying       <= (n_state == DYING);
         anim_done   <= (n_state == DEAD);
         sel_changed <= (n_sel != sprite_sel);
      end
   end

endmodule
